gecko_mem_tracker: RTL and testbench

- Parametrised successor to the fixed-latency memory-result join in the gecko core.
- Stores up to DEPTH outstanding memory operations in issue order, so data memory can return responses in order with any latency.
- Sits between gecko_execute (mem command + data request) and the writeback port.
- Replaces the fixed DATA_LATENCY stage chain with a FIFO, a joined result handshake and error flags.

---
 rtl/gecko_mem_tracker.sv | 128 ++++++++++++
 tb/tb_gecko_mem_tracker.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/gecko_mem_tracker.sv
// In-order tracker for outstanding gecko memory operations; joins each head op with its response.
// Optional head-age timeout monitor enabled by defining GECKO_MEM_TRACKER_TIMEOUT_EN.
module gecko_mem_tracker #(
  parameter int OP_WIDTH       = 64,
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [OP_WIDTH-1:0]          cmd_payload,
  output logic                         req_valid,
  input  logic                         req_ready,
  input  logic                         resp_valid,
  output logic                         resp_ready,
  input  logic [DATA_WIDTH-1:0]        resp_data,
  output logic                         result_valid,
  input  logic                         result_ready,
  output logic [OP_WIDTH-1:0]          result_op,
  output logic [DATA_WIDTH-1:0]        result_data,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding,
  output logic                         full,
  output logic                         empty,
  output logic                         orphan_flag,
  output logic                         timeout_flag
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [OP_WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [CNT_W-1:0]    count_r;
  logic                orphan_r;
  logic                full_s;
  logic                empty_s;
  logic                push_s;
  logic                pop_s;

  // full comes straight from the count register, so cmd_ready never depends on result_ready
  assign full_s  = (count_r == CNT_W'(DEPTH));
  assign empty_s = (count_r == CNT_W'(0));
  assign push_s  = cmd_valid & req_ready & ~full_s;
  assign pop_s   = ~empty_s & resp_valid & result_ready;

  assign req_valid    = cmd_valid & ~full_s;
  assign cmd_ready    = req_ready & ~full_s;
  assign result_valid = ~empty_s & resp_valid;
  assign resp_ready   = empty_s | result_ready;
  assign result_op    = mem_r[rd_ptr_r];
  assign result_data  = resp_data;
  assign outstanding  = count_r;
  assign full         = full_s;
  assign empty        = empty_s;
  assign orphan_flag  = orphan_r;

  // payload storage, written at the write pointer on push
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= cmd_payload;
    end
  end

  // pointers, occupancy and sticky orphan flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
      orphan_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      // a response with nothing outstanding is dropped and remembered
      orphan_r <= orphan_r | (empty_s & resp_valid);
    end
  end

`ifdef GECKO_MEM_TRACKER_TIMEOUT_EN
  localparam int AGE_W = $clog2(TIMEOUT_CYCLES+1);

  logic [AGE_W-1:0] age_r;
  logic [AGE_W-1:0] age_next_s;
  logic             timeout_r;

  // saturating age of the head entry
  always_comb begin
    age_next_s = age_r;
    if (empty_s || pop_s) begin
      age_next_s = AGE_W'(0);
    end else if (age_r != AGE_W'(TIMEOUT_CYCLES)) begin
      age_next_s = age_r + AGE_W'(1);
    end else begin
      age_next_s = age_r;
    end
  end

  // age register and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      age_r     <= AGE_W'(0);
      timeout_r <= 1'b0;
    end else begin
      age_r     <= age_next_s;
      timeout_r <= timeout_r | (age_next_s == AGE_W'(TIMEOUT_CYCLES));
    end
  end

  assign timeout_flag = timeout_r;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT_CYCLES > 0);
  assign timeout_flag     = 1'b0;
`endif

endmodule

// File: tb/tb_gecko_mem_tracker.sv
// Scoreboard bench for gecko_mem_tracker: directed test-plan sequences plus random traffic
// against a queue-based reference model.
module tb_gecko_mem_tracker;

  localparam int OPW = 64;
  localparam int DW  = 32;
  localparam int DEP = 4;
  localparam int TO  = 8;
`ifdef GECKO_MEM_TRACKER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cmd_valid = 1'b0, req_ready = 1'b0, resp_valid = 1'b0, result_ready = 1'b0;
  logic [OPW-1:0] cmd_payload = '0;
  logic [DW-1:0]  resp_data = '0;
  logic           cmd_ready, req_valid, resp_ready, result_valid;
  logic [OPW-1:0] result_op;
  logic [DW-1:0]  result_data;
  logic [2:0]     outstanding;
  logic           full, empty, orphan_flag, timeout_flag;

  gecko_mem_tracker #(.OP_WIDTH(OPW), .DATA_WIDTH(DW), .DEPTH(DEP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_payload(cmd_payload),
    .req_valid(req_valid), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_op(result_op), .result_data(result_data),
    .outstanding(outstanding), .full(full), .empty(empty),
    .orphan_flag(orphan_flag), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             cnt;
    bit             req_valid, cmd_ready, res_valid, resp_ready, orphan, timeout;
    logic [OPW-1:0] op;
    logic [DW-1:0]  data;
  } status_t;

  typedef struct {
    logic [OPW-1:0] op;
    logic [DW-1:0]  data;
  } result_t;

  status_t        status_q[$];
  result_t        res_q[$];
  logic [OPW-1:0] model_q[$];
  bit             orphan_m = 1'b0;
  bit             timeout_m = 1'b0;
  int             age_m = 0;
  int             n_checks = 0;
  int             n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // One clock cycle of stimulus; the model derives expectations from the occupancy before this edge
  task automatic cycle(input bit cv, input logic [OPW-1:0] pl, input bit rq,
                       input bit rv, input logic [DW-1:0] d, input bit rr);
    status_t st;
    int      cnt;
    bit      pop;
    @(posedge clk); #1;
    cmd_valid = cv; cmd_payload = pl; req_ready = rq;
    resp_valid = rv; resp_data = d; result_ready = rr;
    cnt           = model_q.size();
    st.cnt        = cnt;
    st.req_valid  = cv && (cnt != DEP);
    st.cmd_ready  = rq && (cnt != DEP);
    st.res_valid  = (cnt > 0) && rv;
    st.resp_ready = (cnt > 0) ? rr : 1'b1;
    st.op         = (cnt > 0) ? model_q[0] : '0;
    st.data       = d;
    st.orphan     = orphan_m;
    st.timeout    = TO_EN ? timeout_m : 1'b0;
    status_q.push_back(st);
    pop = (cnt > 0) && rv && rr;
    if (pop) res_q.push_back('{op: model_q.pop_front(), data: d});
    if (cnt == 0 && rv) orphan_m = 1'b1;
    if (cnt == 0 || pop) age_m = 0;
    else if (age_m < TO) age_m++;
    if (age_m == TO) timeout_m = 1'b1;
    if (cv && rq && cnt != DEP) model_q.push_back(pl);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    cmd_valid = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; result_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_q.delete();
    orphan_m = 1'b0; timeout_m = 1'b0; age_m = 0;
  endtask

  // Monitor: per-cycle status check and result-handshake scoreboard, away from the active edge
  always @(negedge clk) begin
    status_t st;
    result_t r;
    if (status_q.size() > 0) begin
      st = status_q.pop_front();
      chk("outstanding", 64'(outstanding), 64'(st.cnt));
      chk("full", 64'(full), 64'(st.cnt == DEP));
      chk("empty", 64'(empty), 64'(st.cnt == 0));
      chk("req_valid", 64'(req_valid), 64'(st.req_valid));
      chk("cmd_ready", 64'(cmd_ready), 64'(st.cmd_ready));
      chk("result_valid", 64'(result_valid), 64'(st.res_valid));
      chk("resp_ready", 64'(resp_ready), 64'(st.resp_ready));
      chk("orphan_flag", 64'(orphan_flag), 64'(st.orphan));
      chk("timeout_flag", 64'(timeout_flag), 64'(st.timeout));
      if (st.cnt > 0) chk("head_op", result_op, st.op);
      if (st.res_valid) chk("result_data_pass", 64'(result_data), 64'(st.data));
    end
    if (result_valid && result_ready) begin
      if (res_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL result_unexpected at %0t: got op 0x%0h expected no result", $time, result_op);
      end else begin
        r = res_q.pop_front();
        chk("result_op", result_op, r.op);
        chk("result_data", 64'(result_data), 64'(r.data));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [OPW-1:0] seq;
    do_reset();
    idle(1);
    // fill to DEPTH, then a fifth offer is refused
    for (int i = 1; i <= 4; i++) cycle(1'b1, OPW'(i), 1'b1, 1'b0, '0, 1'b1);
    cycle(1'b1, 64'd5, 1'b1, 1'b0, '0, 1'b1);
    // drain with 0xA0..0xA3
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b1, DW'(32'hA0 + i), 1'b1);
    idle(1);
    // steady stream at occupancy 2 across pointer wrap
    seq = 64'h100;
    for (int i = 0; i < 2; i++) begin cycle(1'b1, seq, 1'b1, 1'b0, '0, 1'b1); seq++; end
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, seq, 1'b1, 1'b1, DW'(32'hB00 + i), 1'b1); seq++;
    end
    for (int i = 0; i < 2; i++) cycle(1'b0, '0, 1'b1, 1'b1, DW'(32'hC0 + i), 1'b1);
    idle(1);
    // downstream stall with response held
    cycle(1'b1, 64'hDEAD_BEEF_0000_0001, 1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b1, 32'h5A5A_0001, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b1, 32'h5A5A_0001, 1'b1);
    idle(1);
    // head age: response at age 7, then no response for 8 cycles
    cycle(1'b1, 64'h77, 1'b1, 1'b0, '0, 1'b1);
    idle(7);
    cycle(1'b0, '0, 1'b1, 1'b1, 32'h7, 1'b1);
    idle(1);
    cycle(1'b1, 64'h88, 1'b1, 1'b0, '0, 1'b1);
    idle(9);
    cycle(1'b0, '0, 1'b1, 1'b1, 32'h8, 1'b1);
    // orphan on empty, and a response in the same cycle as the first push
    cycle(1'b0, '0, 1'b1, 1'b1, 32'hBAD, 1'b1);
    idle(3);
    do_reset();
    cycle(1'b1, 64'h99, 1'b1, 1'b1, 32'hBAD2, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1, 32'h99, 1'b1);
    idle(1);
    do_reset();
    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 3) != 0));
    end
    // drain whatever is left
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b1, DW'($urandom), 1'b1);
    @(posedge clk); @(negedge clk); #1;
    chk("res_q_drained", 64'(res_q.size()), 64'd0);
    chk("status_q_drained", 64'(status_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
